gf_sum_accumulator: RTL and testbench

- Sequential consumer placed directly downstream of the GF/integer adder stage.
- Accumulates a burst of N operand words into one result.
- Mode is fixed per burst by gf_option:
  - GF(2) mode: carry-less, XOR accumulation.
  - Integer mode: ripple-carry style, modulo 2^WIDTH.
- Uses a valid/ready handshake on both input and output, so it can sit between the adder block and a result sink.

---
 rtl/gf_sum_accumulator.sv | 110 +++++++++++
 tb/tb_gf_sum_accumulator.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/gf_sum_accumulator.sv
// Burst accumulator for the adder stage: folds N words into one result, either
// carry-less (XOR) or as a modulo-2^WIDTH integer sum with a sticky carry flag.
module gf_sum_accumulator #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             gf_option,
  input  logic             start,
  input  logic [CNT_W-1:0] num_terms,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mode_q, mode_d;
  logic [WIDTH:0]     sum_w;
  logic               beat_w;

  // One extra bit catches the carry-out of the integer add.
  assign sum_w  = {1'b0, acc_q} + {1'b0, in_data};
  assign beat_w = (state_q == ST_ACCUM) && in_valid;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d = gf_option;
          cnt_d  = num_terms;
          acc_d  = '0;
          ovf_d  = 1'b0;
          if (num_terms == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ACCUM;
          end
        end
      end
      ST_ACCUM: begin
        if (beat_w) begin
          if (mode_q) begin
            acc_d = acc_q ^ in_data;
          end else begin
            acc_d = sum_w[WIDTH-1:0];
            ovf_d = ovf_q | sum_w[WIDTH];
          end
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  // Result is only presented in DONE; everything reads zero otherwise.
  always_comb begin
    in_ready  = (state_q == ST_ACCUM);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q == ST_ACCUM) || (state_q == ST_DONE);
    out_data  = (state_q == ST_DONE) ? acc_q : '0;
    out_ovf   = (state_q == ST_DONE) && ovf_q && !mode_q;
  end

endmodule

// File: tb/tb_gf_sum_accumulator.sv
// Directed bench for gf_sum_accumulator: GF/integer bursts, stalls, empty
// bursts, reset abort and mode latching.
module tb_gf_sum_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        gf_option;
  logic        start;
  logic [4:0]  num_terms;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_ovf;
  logic        busy;

  int checks = 0;
  int errors = 0;

  gf_sum_accumulator #(.WIDTH(32), .CNT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .gf_option (gf_option),
    .start     (start),
    .num_terms (num_terms),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready"},  {31'd0, in_ready},  32'd0);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_out_ovf"},   {31'd0, out_ovf},   32'd0);
    chk({tag, "_busy"},      {31'd0, busy},      32'd0);
    chk({tag, "_out_data"},  out_data,           32'd0);
  endtask

  initial begin
    rst = 1'b1; gf_option = 1'b0; start = 1'b0; num_terms = 5'd0;
    in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0;
    @(negedge clk);
    tick();
    tick();
    chk_idle("reset");
    rst = 1'b0;
    tick();
    chk_idle("idle_after_reset");

    // GF burst of three words
    gf_option = 1'b1; num_terms = 5'd3; start = 1'b1;
    in_valid = 1'b1; in_data = 32'h0000_00FF;
    tick();
    start = 1'b0;
    chk("gf_in_ready", {31'd0, in_ready}, 32'd1);
    chk("gf_busy", {31'd0, busy}, 32'd1);
    tick();
    in_data = 32'h0000_0F0F;
    tick();
    chk("gf_not_yet_valid", {31'd0, out_valid}, 32'd0);
    in_data = 32'hFFFF_0000;
    tick();
    in_valid = 1'b0;
    chk("gf_out_valid", {31'd0, out_valid}, 32'd1);
    chk("gf_out_data", out_data, 32'hFFFF_0FF0);
    chk("gf_out_ovf", {31'd0, out_ovf}, 32'd0);
    chk("gf_done_in_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("gf_back_idle", {31'd0, busy}, 32'd0);

    // Integer burst that wraps
    gf_option = 1'b0; num_terms = 5'd2; start = 1'b1;
    in_valid = 1'b1; in_data = 32'hFFFF_FFFF;
    tick();
    start = 1'b0;
    tick();
    in_data = 32'h0000_0002;
    tick();
    in_valid = 1'b0;
    chk("int_out_valid", {31'd0, out_valid}, 32'd1);
    chk("int_out_data", out_data, 32'h0000_0001);
    chk("int_out_ovf", {31'd0, out_ovf}, 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("int_back_idle", {31'd0, out_valid}, 32'd0);

    // Integer burst with in_valid toggling
    gf_option = 1'b0; num_terms = 5'd4; start = 1'b1;
    in_data = 32'h10; in_valid = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = (i % 2 == 0);
      tick();
      if (i < 6) chk($sformatf("stall_early_%0d", i), {31'd0, out_valid}, 32'd0);
    end
    in_valid = 1'b0;
    chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
    chk("stall_out_data", out_data, 32'h40);
    chk("stall_out_ovf", {31'd0, out_ovf}, 32'd0);

    // Output back-pressure: result holds and start is ignored
    num_terms = 5'd1;
    for (int i = 0; i < 5; i++) begin
      start = 1'b1;
      tick();
      chk($sformatf("bp_valid_%0d", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("bp_data_%0d", i), out_data, 32'h40);
    end
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    chk("bp_released_idle", {31'd0, busy}, 32'd0);
    tick();
    chk("bp_stays_idle", {31'd0, busy}, 32'd0);

    // Empty burst
    gf_option = 1'b0; num_terms = 5'd0; start = 1'b1;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
    tick();
    start = 1'b0;
    chk("zero_out_valid", {31'd0, out_valid}, 32'd1);
    chk("zero_out_data", out_data, 32'd0);
    chk("zero_out_ovf", {31'd0, out_ovf}, 32'd0);
    chk("zero_in_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("zero_back_idle", {31'd0, busy}, 32'd0);

    // Reset after two of four beats
    gf_option = 1'b0; num_terms = 5'd4; start = 1'b1;
    in_valid = 1'b1; in_data = 32'h7;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk_idle("abort");
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
    chk_idle("abort_idle");

    // Fresh single-word burst after abort
    gf_option = 1'b0; num_terms = 5'd1; start = 1'b1;
    in_valid = 1'b1; in_data = 32'h5; out_ready = 1'b0;
    tick();
    start = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("after_abort_valid", {31'd0, out_valid}, 32'd1);
    chk("after_abort_data", out_data, 32'h5);
    chk("after_abort_ovf", {31'd0, out_ovf}, 32'd0);
    out_ready = 1'b1;
    tick();

    // Mode latched at start despite gf_option changing
    gf_option = 1'b1; num_terms = 5'd2; start = 1'b1;
    in_valid = 1'b1; in_data = 32'h3; out_ready = 1'b0;
    tick();
    start = 1'b0;
    gf_option = 1'b0;
    tick();
    in_data = 32'h1;
    tick();
    in_valid = 1'b0;
    chk("latch_valid", {31'd0, out_valid}, 32'd1);
    chk("latch_data", out_data, 32'h2);
    chk("latch_ovf", {31'd0, out_ovf}, 32'd0);
    out_ready = 1'b1;
    tick();
    chk("latch_back_idle", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
